// File: rtl/dilate_3x3.sv
// dilate_3x3: binary 3x3 morphological dilation (0 = feature) with
// two-stage aligned VGA timing pass-through.
//
// Parameters:
//   H_ACTIVE  active pixels per line (line-buffer depth)
//   V_ACTIVE  active lines per frame (border mask only)
//
// Ports:
//   clk, rst              pixel clock, synchronous active-high reset
//   hs, vs, de            input timing
//   h_cnt, v_cnt          input active column / line
//   bin                   input binary pixel (0 = edge/feature)
//   dilate                dilated pixel
//   dil_hs, dil_vs,
//   dil_de, dil_h_cnt,
//   dil_v_cnt             timing delayed to match dilate (2 clk)
//
// Build option:
//   DILATE_BORDER_MASK_EN  force dilate=1 where the window is incomplete
//                          (dil_h_cnt<2 or dil_v_cnt<2)

module dilate_3x3 #(
    parameter int H_ACTIVE = 1024,
    parameter int V_ACTIVE = 768
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hs,
    input  logic        vs,
    input  logic        de,
    input  logic [11:0] h_cnt,
    input  logic [11:0] v_cnt,
    input  logic        bin,
    output logic        dilate,
    output logic        dil_hs,
    output logic        dil_vs,
    output logic        dil_de,
    output logic [11:0] dil_h_cnt,
    output logic [11:0] dil_v_cnt
);

    localparam int AW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;

    // ------------------------------------------------------------
    // Line buffers: LB0 = line y-1, LB1 = line y-2 (cascade)
    // ------------------------------------------------------------
    logic          r_lb0 [H_ACTIVE];
    logic          r_lb1 [H_ACTIVE];
    logic          r_rd0;
    logic          r_rd1;

    logic [AW-1:0] w_addr;
    logic          w_in_range;
    logic          w_wr;

    assign w_addr     = h_cnt[AW-1:0];
    assign w_in_range = (h_cnt < 12'(H_ACTIVE));
    assign w_wr       = de & w_in_range;

    // RAM and its read register carry no reset. Reads return the
    // pre-write contents, so LB0 yields line y-1 while it is being
    // overwritten with line y, and that old value moves into LB1.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_lb0[w_addr] <= bin;
            r_lb1[w_addr] <= r_lb0[w_addr];
            r_rd0         <= r_lb0[w_addr];
            r_rd1         <= r_lb1[w_addr];
        end
    end

    // ------------------------------------------------------------
    // Stage 1: input register and row-validity flags
    // ------------------------------------------------------------
    logic        r_s1_bin;
    logic        r_s1_hs;
    logic        r_s1_vs;
    logic        r_s1_de;
    logic [11:0] r_s1_h;
    logic [11:0] r_s1_v;
    logic        r_s1_row1_ok;
    logic        r_s1_row2_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_bin     <= 1'b0;
            r_s1_hs      <= 1'b0;
            r_s1_vs      <= 1'b0;
            r_s1_de      <= 1'b0;
            r_s1_h       <= 12'd0;
            r_s1_v       <= 12'd0;
            r_s1_row1_ok <= 1'b0;
            r_s1_row2_ok <= 1'b0;
        end else begin
            r_s1_bin     <= bin;
            r_s1_hs      <= hs;
            r_s1_vs      <= vs;
            r_s1_de      <= de;
            r_s1_h       <= h_cnt;
            r_s1_v       <= v_cnt;
            r_s1_row1_ok <= (v_cnt >= 12'd1);
            r_s1_row2_ok <= (v_cnt >= 12'd2);
        end
    end

    // Rows above the top of the frame read as background so that
    // the previous frame's bottom lines never leak in.
    logic       w_tap1;
    logic       w_tap2;
    logic [2:0] w_new_col;

    assign w_tap1    = r_s1_row1_ok ? r_rd0 : 1'b1;
    assign w_tap2    = r_s1_row2_ok ? r_rd1 : 1'b1;
    assign w_new_col = {r_s1_bin, w_tap1, w_tap2};

    // ------------------------------------------------------------
    // Stage 2: 3x3 window shift register and timing
    // Each column is {row y, row y-1, row y-2}; col0 is newest.
    // ------------------------------------------------------------
    logic [2:0]  r_col0;
    logic [2:0]  r_col1;
    logic [2:0]  r_col2;
    logic        r_s2_hs;
    logic        r_s2_vs;
    logic        r_s2_de;
    logic [11:0] r_s2_h;
    logic [11:0] r_s2_v;

    // Blanking reloads every cell with background, which pads the
    // left edge of the next line and prevents wrap from the right.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_col0 <= 3'b111;
            r_col1 <= 3'b111;
            r_col2 <= 3'b111;
        end else if (!r_s1_de) begin
            r_col0 <= 3'b111;
            r_col1 <= 3'b111;
            r_col2 <= 3'b111;
        end else begin
            r_col2 <= r_col1;
            r_col1 <= r_col0;
            r_col0 <= w_new_col;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_hs <= 1'b0;
            r_s2_vs <= 1'b0;
            r_s2_de <= 1'b0;
            r_s2_h  <= 12'd0;
            r_s2_v  <= 12'd0;
        end else begin
            r_s2_hs <= r_s1_hs;
            r_s2_vs <= r_s1_vs;
            r_s2_de <= r_s1_de;
            r_s2_h  <= r_s1_h;
            r_s2_v  <= r_s1_v;
        end
    end

    // ------------------------------------------------------------
    // Result
    // ------------------------------------------------------------
    logic w_win_and;
    logic w_mask;

    assign w_win_and = &{r_col2, r_col1, r_col0};

`ifdef DILATE_BORDER_MASK_EN
    assign w_mask = (r_s2_h < 12'd2) ||
                    (r_s2_v < 12'd2) ||
                    (r_s2_v >= 12'(V_ACTIVE));
`else
    assign w_mask = 1'b0;
`endif

    assign dilate    = ~r_s2_de | w_mask | w_win_and;
    assign dil_hs    = r_s2_hs;
    assign dil_vs    = r_s2_vs;
    assign dil_de    = r_s2_de;
    assign dil_h_cnt = r_s2_h;
    assign dil_v_cnt = r_s2_v;

endmodule
